// File: rtl/imm_decode_stage.sv
// imm_decode_stage: splits a MIPS I-type instruction into fields and an
// extended immediate, registering the decoded record behind a 2-entry skid
// buffer so execute-side backpressure can stall fetch without losing a word.
module imm_decode_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [5:0]       out_opcode,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [15:0]      out_imm16,
  output logic [31:0]      out_imm_ext,
  output logic             out_is_lui,
  output logic             out_is_itype,
  output logic [CNT_W-1:0] out_count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm16;
    logic [31:0] imm_ext;
    logic        is_lui;
    logic        is_itype;
  } rec_t;

  rec_t             in_rec;
  rec_t             main_data_reg, main_data_next;
  rec_t             skid_data_reg, skid_data_next;
  logic             main_valid_reg, main_valid_next;
  logic             skid_valid_reg, skid_valid_next;
  logic             in_ready_reg;
  logic [CNT_W-1:0] count_reg;
  logic             accept;
  logic             drain;
  logic             zero_ext;

  assign accept = in_valid & in_ready_reg;
  assign drain  = main_valid_reg & out_ready;

  // Decode the incoming word; only the logical-immediate ops zero-extend.
  always_comb begin
    in_rec          = '0;
    in_rec.pc       = in_pc;
    in_rec.opcode   = in_instr[31:26];
    in_rec.rs       = in_instr[25:21];
    in_rec.rt       = in_instr[20:16];
    in_rec.imm16    = in_instr[15:0];
    zero_ext        = (in_instr[31:26] == 6'h0C) || (in_instr[31:26] == 6'h0D) ||
                      (in_instr[31:26] == 6'h0E);
    in_rec.imm_ext  = zero_ext ? {16'h0000, in_instr[15:0]}
                               : {{16{in_instr[15]}}, in_instr[15:0]};
    in_rec.is_lui   = (in_instr[31:26] == 6'h0F);
    in_rec.is_itype = !((in_instr[31:26] == 6'h00) || (in_instr[31:26] == 6'h02) ||
                        (in_instr[31:26] == 6'h03));
  end

  // Next-state of the main/skid pair; skid always drains into main first to keep order.
  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (!main_valid_reg || drain) begin
      if (skid_valid_reg) begin
        main_valid_next = 1'b1;
        main_data_next  = skid_data_reg;
        skid_valid_next = accept;
        if (accept) begin
          skid_data_next = in_rec;
        end
      end else begin
        main_valid_next = accept;
        if (accept) begin
          main_data_next = in_rec;
        end
      end
    end else if (accept) begin
      skid_valid_next = 1'b1;
      skid_data_next  = in_rec;
    end
  end

  // Register the buffer state; in_ready is the registered inverse of the next skid valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      skid_data_reg  <= '0;
      in_ready_reg   <= 1'b1;
    end else begin
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      main_data_reg  <= main_data_next;
      skid_data_reg  <= skid_data_next;
      in_ready_reg   <= ~skid_valid_next;
    end
  end

  // Count completed output transfers, including one that coincides with a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (drain) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign in_ready     = in_ready_reg;
  assign out_valid    = main_valid_reg;
  assign out_pc       = main_data_reg.pc;
  assign out_opcode   = main_data_reg.opcode;
  assign out_rs       = main_data_reg.rs;
  assign out_rt       = main_data_reg.rt;
  assign out_imm16    = main_data_reg.imm16;
  assign out_imm_ext  = main_data_reg.imm_ext;
  assign out_is_lui   = main_data_reg.is_lui;
  assign out_is_itype = main_data_reg.is_itype;
  assign out_count    = count_reg;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: decode, extension, backpressure,
// flush, counter wrap (CNT_W = 4) and asynchronous reset.
module tb_imm_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [15:0] out_imm16;
  logic [31:0] out_imm_ext;
  logic        out_is_lui;
  logic        out_is_itype;
  logic [3:0]  out_count;

  int tests_run;
  int tests_failed;

  imm_decode_stage #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt),
    .out_imm16(out_imm16), .out_imm_ext(out_imm_ext),
    .out_is_lui(out_is_lui), .out_is_itype(out_is_itype), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded, required finish before 100000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Advance past the next rising edge; inputs are changed and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    #12;
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst in_ready", {31'b0, in_ready}, 32'd1);
    check("rst count", {28'b0, out_count}, 32'd0);
    check("rst pc", out_pc, 32'd0);
    check("rst imm_ext", out_imm_ext, 32'd0);
    rst_n = 1'b1;
    tick();

    // Streaming decode with out_ready high.
    out_ready = 1'b1;
    offer(32'h3C081234, 32'h100);
    tick();
    check("lui valid", {31'b0, out_valid}, 32'd1);
    check("lui opcode", {26'b0, out_opcode}, 32'h0F);
    check("lui rt", {27'b0, out_rt}, 32'd8);
    check("lui imm16", {16'b0, out_imm16}, 32'h1234);
    check("lui imm_ext", out_imm_ext, 32'h00001234);
    check("lui is_lui", {31'b0, out_is_lui}, 32'd1);
    check("lui is_itype", {31'b0, out_is_itype}, 32'd1);
    check("lui count", {28'b0, out_count}, 32'd0);
    offer(32'h2008FFFF, 32'h104);
    tick();
    check("addi imm_ext", out_imm_ext, 32'hFFFFFFFF);
    check("addi pc", out_pc, 32'h104);
    check("addi count", {28'b0, out_count}, 32'd1);
    offer(32'h3508FFFF, 32'h108);
    tick();
    check("ori imm_ext", out_imm_ext, 32'h0000FFFF);
    check("ori rs", {27'b0, out_rs}, 32'd8);
    check("ori rt", {27'b0, out_rt}, 32'd8);
    check("ori is_lui", {31'b0, out_is_lui}, 32'd0);
    offer(32'h08008000, 32'h10C);
    tick();
    check("j is_itype", {31'b0, out_is_itype}, 32'd0);
    check("j imm_ext", out_imm_ext, 32'hFFFF8000);
    in_valid = 1'b0;
    tick();
    check("idle valid", {31'b0, out_valid}, 32'd0);
    check("idle count", {28'b0, out_count}, 32'd4);

    // Backpressure: A held, B in skid, C refused until space frees.
    out_ready = 1'b0;
    offer(32'h20010001, 32'h200);
    tick();
    check("bp A valid", {31'b0, out_valid}, 32'd1);
    check("bp one in_ready", {31'b0, in_ready}, 32'd1);
    offer(32'h20020002, 32'h204);
    tick();
    check("bp full in_ready", {31'b0, in_ready}, 32'd0);
    check("bp A held", out_pc, 32'h200);
    offer(32'h20030003, 32'h208);
    tick();
    check("bp C refused", {31'b0, in_ready}, 32'd0);
    check("bp A stable", out_pc, 32'h200);
    check("bp A imm", out_imm_ext, 32'h00000001);
    out_ready = 1'b1;
    tick();
    check("bp B out", out_pc, 32'h204);
    check("bp in_ready up", {31'b0, in_ready}, 32'd1);
    check("bp count1", {28'b0, out_count}, 32'd5);
    tick();
    check("bp C out", out_pc, 32'h208);
    check("bp C imm", out_imm_ext, 32'h00000003);
    in_valid = 1'b0;
    tick();
    check("bp drained", {31'b0, out_valid}, 32'd0);
    check("bp count", {28'b0, out_count}, 32'd7);

    // Flush from FULL with an offered instruction.
    out_ready = 1'b0;
    offer(32'h20040004, 32'h300);
    tick();
    offer(32'h20050005, 32'h304);
    tick();
    check("fl full", {31'b0, in_ready}, 32'd0);
    offer(32'h20060006, 32'h308);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl valid", {31'b0, out_valid}, 32'd0);
    check("fl in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("fl no ghost", {31'b0, out_valid}, 32'd0);
    check("fl count", {28'b0, out_count}, 32'd7);
    // Flush from ONE while draining and offering: drain counts, offer discarded.
    offer(32'h20070007, 32'h30C);
    tick();
    offer(32'h20080008, 32'h310);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl2 valid", {31'b0, out_valid}, 32'd0);
    check("fl2 count", {28'b0, out_count}, 32'd8);
    tick();
    check("fl2 no ghost", {31'b0, out_valid}, 32'd0);

    // Nine more drains: 17 total wraps the 4-bit counter to 1.
    for (int i = 0; i < 9; i++) begin
      offer(32'h20090000 | i, 32'h400 + 4 * i);
      tick();
      check($sformatf("wrap pc%0d", i), out_pc, 32'h400 + 4 * i);
    end
    in_valid = 1'b0;
    tick();
    check("wrap count", {28'b0, out_count}, 32'd1);

    // Asynchronous reset between edges while FULL.
    out_ready = 1'b0;
    offer(32'h3C0AABCD, 32'h500);
    tick();
    offer(32'h3C0B1111, 32'h504);
    tick();
    in_valid = 1'b0;
    check("ar full", {31'b0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar valid", {31'b0, out_valid}, 32'd0);
    check("ar in_ready", {31'b0, in_ready}, 32'd1);
    check("ar count", {28'b0, out_count}, 32'd0);
    check("ar pc", out_pc, 32'd0);
    check("ar imm16", {16'b0, out_imm16}, 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    check("ar stays empty", {31'b0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
